// File: rtl/vga_scan_ctrl.sv
// VGA raster scan controller: pixel/line counters, registered syncs,
// visible/valid flag, image-window address generation and RGB capture.
//
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   pix_ce               - pixel clock enable; timing advances only when high
//   vga_data[23:0]       - pixel {R,G,B} from source, combinational on h/v_addr
//   h_addr[9:0]          - requested column (0 outside the image window)
//   v_addr[8:0]          - requested row (0 outside the image window)
//   hsync, vsync         - registered, active-low syncs
//   valid                - registered, high in the visible area
//   vga_r/g/b[7:0]       - registered colour, 0 outside the image window
//   frame_start          - one clk pulse aligned with output pixel (0,0)
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  input  logic [23:0] vga_data,
  output logic [9:0]  h_addr,
  output logic [8:0]  v_addr,
  output logic        hsync,
  output logic        vsync,
  output logic        valid,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] H_IMG  = 10'(IMG_W);
  localparam logic [9:0] V_IMG  = 10'(IMG_H);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_end;
  logic       v_end;
  logic       vis;
  logic       img;
  logic       hs_on;
  logic       vs_on;

  assign h_end = (h_cnt == H_LAST);
  assign v_end = (v_cnt == V_LAST);
  assign vis   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign img   = vis && (h_cnt < H_IMG) && (v_cnt < V_IMG);
  assign hs_on = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
  assign vs_on = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);

  // Address is forced to 0 outside the window so the source never
  // sees an out-of-range request.
  assign h_addr = img ? h_cnt : '0;
  assign v_addr = img ? v_cnt[8:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      valid       <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      h_cnt <= h_end ? '0 : h_cnt + 10'd1;
      if (h_end) begin
        v_cnt <= v_end ? '0 : v_cnt + 10'd1;
      end
      hsync       <= ~hs_on;
      vsync       <= ~vs_on;
      valid       <= vis;
      {vga_r, vga_g, vga_b} <= img ? vga_data : 24'h0;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end else begin
      // Everything else holds; the pulse must last one clk only.
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Self-checking bench for vga_scan_ctrl using a reduced raster
// so several whole frames fit in a short run.
module tb_vga_scan_ctrl;

  localparam int HA = 16;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int HB = 3;
  localparam int VA = 12;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_ce;
  logic [23:0] vga_data;
  logic [9:0]  h_addr;
  logic [8:0]  v_addr;
  logic        hsync;
  logic        vsync;
  logic        valid;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        frame_start;
  logic [7:0]  salt;

  int checks = 0;
  int errors = 0;

  // model state: pixels processed since reset, modulo one frame
  int  p;
  bit  known;
  logic        e_hs, e_vs, e_vld, e_fs;
  logic [23:0] e_rgb;

  // statistics for the directed scenarios
  int cyc_no, oc, hs_low, vs_low, vld_cnt, fs_cnt;
  int last_fs, fs_period, hs_first;

  always #5 clk = ~clk;

  assign vga_data = {h_addr[7:0], v_addr[7:0], salt};

  vga_scan_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .IMG_W(IW), .IMG_H(IH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_ce(pix_ce),
    .vga_data(vga_data),
    .h_addr(h_addr),
    .v_addr(v_addr),
    .hsync(hsync),
    .vsync(vsync),
    .valid(valid),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .frame_start(frame_start)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    cyc_no = 0; oc = 0; hs_low = 0; vs_low = 0; vld_cnt = 0;
    fs_cnt = 0; last_fs = -1; fs_period = -1; hs_first = 0;
  endtask

  function automatic bit in_img(input int x, input int y);
    return x < HA && y < VA && x < IW && y < IH;
  endfunction

  // One clk cycle: drive, check addresses, clock, update model, check.
  task automatic cyc(input bit ce, input bit r);
    int x, y;
    bit im;
    pix_ce = ce;
    rst    = r;
    salt   = 8'($urandom);
    x  = p % HT;
    y  = p / HT;
    im = in_img(x, y);
    #1;
    if (known && !r) begin
      chk("h_addr", 32'(h_addr), im ? 32'(x) : 32'd0);
      chk("v_addr", 32'(v_addr), im ? 32'(y) : 32'd0);
    end
    @(posedge clk);
    #1;
    if (r) begin
      e_hs = 1; e_vs = 1; e_vld = 0; e_rgb = '0; e_fs = 0;
      p = 0;
      known = 1;
    end else if (ce) begin
      e_hs  = !(x >= HA + HF && x < HA + HF + HS);
      e_vs  = !(y >= VA + VF && y < VA + VF + VS);
      e_vld = x < HA && y < VA;
      e_rgb = im ? {8'(x), 8'(y), salt} : 24'h0;
      e_fs  = (p == 0);
      p = (p + 1) % FT;
    end else begin
      e_fs = 0;
    end
    if (known) begin
      chk("hsync", 32'(hsync), 32'(e_hs));
      chk("vsync", 32'(vsync), 32'(e_vs));
      chk("valid", 32'(valid), 32'(e_vld));
      chk("rgb", 32'({vga_r, vga_g, vga_b}), 32'(e_rgb));
      chk("frame_start", 32'(frame_start), 32'(e_fs));
    end
    cyc_no++;
    if (ce && !r) begin
      oc++;
      if (!hsync) begin
        hs_low++;
        if (hs_first == 0) hs_first = oc;
      end
      if (!vsync) vs_low++;
      if (valid) vld_cnt++;
    end
    if (frame_start) begin
      fs_cnt++;
      if (last_fs >= 0) fs_period = cyc_no - last_fs;
      last_fs = cyc_no;
    end
  endtask

  initial begin
    rst = 1'b1;
    pix_ce = 1'b0;
    salt = 8'h5A;
    p = 0;
    known = 0;
    clr_stats();

    // reset, with pix_ce both low and high
    cyc(0, 1);
    cyc(1, 1);

    // free run two frames at constant pix_ce
    clr_stats();
    for (int i = 0; i < 2 * FT; i++) cyc(1, 0);
    chk("fs_count_const", 32'(fs_cnt), 32'd2);
    chk("fs_period_const", 32'(fs_period), 32'(FT));
    chk("hs_first_index", 32'(hs_first), 32'(HA + HF + 1));
    chk("hs_low_cycles", 32'(hs_low), 32'(2 * HS * VT));
    chk("vs_low_cycles", 32'(vs_low), 32'(2 * VS * HT));
    chk("valid_cycles", 32'(vld_cnt), 32'(2 * HA * VA));

    // pix_ce toggling: same sequence, every value held two clks
    clr_stats();
    for (int i = 0; i < 2 * FT; i++) begin
      cyc(1, 0);
      cyc(0, 0);
    end
    chk("fs_count_toggle", 32'(fs_cnt), 32'd2);
    chk("fs_period_toggle", 32'(fs_period), 32'(2 * FT));
    chk("valid_cycles_toggle", 32'(vld_cnt), 32'(2 * HA * VA));

    // random enables; blanking and out-of-window data changes
    for (int i = 0; i < 800; i++) cyc(1'($urandom_range(0, 1)), 0);

    // reset mid-frame, then idle, then resume
    while (p != 5 * HT + 10) cyc(1, 0);
    cyc(1, 1);
    cyc(0, 0);
    cyc(0, 0);
    clr_stats();
    cyc(1, 0);
    chk("fs_after_reset", 32'(fs_cnt), 32'd1);
    for (int i = 0; i < 300; i++) cyc(1'($urandom_range(0, 1)), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
